// File: rtl/word_assembler.sv
// Serial-to-parallel word builder: collects P payload bits under valid/ready, prepends a
// constant marker field and queues finished words in a small output FIFO.
module word_assembler #(
  parameter int WORD_W    = 12,
  parameter int MARKER_W  = 1,
  parameter int MARKER    = 1,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 1,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_bit,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WORD_W-1:0]        word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int P  = WORD_W - MARKER_W;
  localparam int CW = $clog2(P + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int AW = $clog2(DEPTH);

  // Marker bits pre-shifted into the top of the word; bits beyond WORD_W fall off.
  localparam logic [WORD_W-1:0] MARKER_FIELD =
      (MARKER_W == 0) ? '0 : (WORD_W'(MARKER) << P);

  localparam logic [1:0] StCollect = 2'd0;
  localparam logic [1:0] StPush    = 2'd1;
  localparam logic [1:0] StGap     = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [P-1:0]      payload_q, payload_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [CW-1:0]     bit_idx;
  logic              accept;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              push, pop, full, wr_en;
  logic [WORD_W-1:0] word_in;

  always_comb begin
    in_ready  = (state_q == StCollect) && !rst;
    accept    = in_valid && in_ready;
    bit_idx   = (MSB_FIRST != 0) ? (CW'(P - 1) - cnt_q) : cnt_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    payload_d = payload_q;
    gap_d     = gap_q;
    case (state_q)
      StCollect: begin
        if (accept) begin
          for (int i = 0; i < P; i++) begin
            if (bit_idx == CW'(i)) payload_d[i] = in_bit;
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(P - 1)) state_d = StPush;
        end
      end
      StPush: begin
        cnt_d     = '0;
        payload_d = '0;
        gap_d     = '0;
        state_d   = (GAP > 0) ? StGap : StCollect;
      end
      StGap: begin
        if (gap_q == GW'(GAP - 1)) state_d = StCollect;
        else                       gap_d   = gap_q + GW'(1);
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StCollect;
      cnt_q     <= '0;
      payload_q <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      payload_q <= payload_d;
      gap_q     <= gap_d;
    end
  end

  // A push into a full FIFO still lands when the head is popped in the same cycle.
  always_comb begin
    word_in    = MARKER_FIELD | WORD_W'(payload_q);
    push       = (state_q == StPush);
    full       = (count_q == (AW + 1)'(DEPTH));
    word_valid = (count_q != '0) && !rst;
    pop        = word_valid && word_ready;
    wr_en      = push && (!full || pop);
    overflow   = push && full && !pop && !rst;
    word_out   = word_valid ? mem[rd_ptr_q] : '0;
    fill       = rst ? '0 : count_q;
    count_d    = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr_q] <= word_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_word_assembler.sv
// Scoreboard bench for word_assembler: three instances cover default, LSB-first and
// gapless marker-free configurations.
module tb_word_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic drv_bit, drv_valid;
  int   sel;
  logic wr_a, wr_b, wr_c;

  logic        ir_a, wv_a, ov_a;
  logic [11:0] wo_a;
  logic [2:0]  fl_a;
  logic        ir_b, wv_b, ov_b;
  logic [11:0] wo_b;
  logic [2:0]  fl_b;
  logic        ir_c, wv_c, ov_c;
  logic [7:0]  wo_c;
  logic [2:0]  fl_c;
  logic        rdy_sel;

  int n_checks = 0;
  int n_fail   = 0;
  int ovf_a    = 0;
  int st;
  logic [31:0] q_a[$], q_b[$], q_c[$];
  logic [31:0] mon_exp;

  assign rdy_sel = (sel == 0) ? ir_a : (sel == 1) ? ir_b : ir_c;

  word_assembler u_a (
    .clk(clk), .rst(rst), .in_bit(drv_bit), .in_valid(drv_valid && sel == 0),
    .in_ready(ir_a), .word_out(wo_a), .word_valid(wv_a), .word_ready(wr_a),
    .overflow(ov_a), .fill(fl_a)
  );

  word_assembler #(.MSB_FIRST(0)) u_b (
    .clk(clk), .rst(rst), .in_bit(drv_bit), .in_valid(drv_valid && sel == 1),
    .in_ready(ir_b), .word_out(wo_b), .word_valid(wv_b), .word_ready(wr_b),
    .overflow(ov_b), .fill(fl_b)
  );

  word_assembler #(.WORD_W(8), .MARKER_W(0), .GAP(0)) u_c (
    .clk(clk), .rst(rst), .in_bit(drv_bit), .in_valid(drv_valid && sel == 2),
    .in_ready(ir_c), .word_out(wo_c), .word_valid(wv_c), .word_ready(wr_c),
    .overflow(ov_c), .fill(fl_c)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got word %0h expected no word", name, act);
  endtask

  // Monitor: every popped word is compared with the head of its instance's queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (wv_a && wr_a) begin
        if (q_a.size() == 0) unexpected("word_a", 32'(wo_a));
        else begin mon_exp = q_a.pop_front(); chk("word_a", 32'(wo_a), mon_exp); end
      end
      if (wv_b && wr_b) begin
        if (q_b.size() == 0) unexpected("word_b", 32'(wo_b));
        else begin mon_exp = q_b.pop_front(); chk("word_b", 32'(wo_b), mon_exp); end
      end
      if (wv_c && wr_c) begin
        if (q_c.size() == 0) unexpected("word_c", 32'(wo_c));
        else begin mon_exp = q_c.pop_front(); chk("word_c", 32'(wo_c), mon_exp); end
      end
      if (ov_a) ovf_a++;
    end
  end

  // Bits are sent bits[n-1] first; returns the number of cycles the source was stalled.
  task automatic feed(input logic [31:0] bits, input int n, input bit toggle,
                      output int stalls);
    stalls = 0;
    for (int k = 0; k < n; k++) begin
      int guard;
      if (toggle) begin
        drv_valid = 1'b0;
        @(posedge clk); #1;
      end
      drv_bit   = bits[n-1-k];
      drv_valid = 1'b1;
      guard     = 0;
      @(negedge clk);
      while (!rdy_sel && guard < 20) begin
        stalls++;
        guard++;
        @(negedge clk);
      end
      if (guard == 20) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: got in_ready 0 expected 1 within 20 cycles");
      end
      @(posedge clk); #1;
    end
    drv_valid = 1'b0;
  endtask

  task automatic drain_a();
    wr_a = 1'b1;
    for (int i = 0; i < 20 && fl_a != 0; i++) @(negedge clk);
    chk("drain_fill", 32'(fl_a), 0);
    chk("drain_queue", q_a.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; drv_valid = 1'b0; drv_bit = 1'b0;
    wr_a = 1'b1; wr_b = 1'b1; wr_c = 1'b1; sel = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 32'(ir_a), 0);
    chk("reset_valid", 32'(wv_a), 0);
    chk("reset_fill", 32'(fl_a), 0);
    chk("reset_overflow", 32'(ov_a), 0);
    chk("reset_word_out", 32'(wo_a), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(ir_a), 1);
    chk("valid_after_reset", 32'(wv_a), 0);
    @(posedge clk); #1;

    // Alternating pattern, MSB first, marker 1.
    q_a.push_back(32'hD55);
    feed(32'h555, 11, 1'b0, st);
    @(negedge clk);
    chk("t1_push_ready", 32'(ir_a), 0);
    chk("t1_push_valid", 32'(wv_a), 0);
    @(negedge clk);
    chk("t1_gap_ready", 32'(ir_a), 0);
    chk("t1_valid", 32'(wv_a), 1);
    @(negedge clk);
    chk("t1_ready_back", 32'(ir_a), 1);
    chk("t1_drained", 32'(wv_a), 0);
    @(posedge clk); #1;

    // LSB first, continuous then sparse valid.
    sel = 1;
    q_b.push_back(32'h803);
    q_b.push_back(32'h803);
    feed(32'h600, 11, 1'b0, st);
    feed(32'h600, 11, 1'b1, st);
    repeat (4) @(posedge clk); #1;
    chk("t2_queue", q_b.size(), 0);

    // Fill the FIFO with the consumer stalled; the fifth word overflows.
    sel = 0;
    wr_a = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) q_a.push_back(32'h800 | k);
      feed(32'(k), 11, 1'b0, st);
      @(negedge clk);
      chk("t3_overflow", 32'(ov_a), (k == 5) ? 1 : 0);
      @(negedge clk);
      chk("t3_fill", 32'(fl_a), (k < 4) ? k : 4);
      @(posedge clk); #1;
    end
    chk("t3_overflow_count", ovf_a, 1);
    drain_a();
    wr_a = 1'b0;

    // Full FIFO with a pop in the PUSH cycle: word is accepted, no overflow.
    for (int k = 6; k <= 10; k++) q_a.push_back(32'h800 | k);
    for (int k = 6; k <= 9; k++) feed(32'(k), 11, 1'b0, st);
    feed(32'd10, 11, 1'b0, st);
    wr_a = 1'b1;
    @(negedge clk);
    chk("t4_overflow", 32'(ov_a), 0);
    chk("t4_fill_pre", 32'(fl_a), 4);
    @(posedge clk); #1 wr_a = 1'b0;
    @(negedge clk);
    chk("t4_fill_post", 32'(fl_a), 4);
    chk("t4_overflow_count", ovf_a, 1);
    @(posedge clk); #1;
    drain_a();

    // Reset mid-word discards the partial payload.
    feed(32'h16, 5, 1'b0, st);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_ready", 32'(ir_a), 0);
    chk("t5_rst_valid", 32'(wv_a), 0);
    @(posedge clk); #1 rst = 1'b0;
    q_a.push_back(32'hFFF);
    feed(32'h7FF, 11, 1'b0, st);
    repeat (4) @(posedge clk); #1;
    chk("t5_queue", q_a.size(), 0);

    // No gap, no marker: one stall cycle between back-to-back words.
    sel = 2;
    q_c.push_back(32'hFF);
    q_c.push_back(32'hFF);
    feed(32'hFFFF, 16, 1'b0, st);
    chk("t6_stall_cycles", st, 1);
    repeat (4) @(posedge clk); #1;
    chk("t6_queue", q_c.size(), 0);
    chk("final_fill_c", 32'(fl_c), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
